// File: rtl/nd_2to1_if.sv
// Two-phase toggle channel: req toggles to offer dat, ack copies req to accept it.
// A channel is pending while req != ack; the sender holds dat stable until then.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 16
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif

interface nd_2to1_if #(
  parameter int DSZ = `NS_DATA_SIZE
);
  logic           req;
  logic           ack;
  logic [DSZ-1:0] dat;

  modport master (output req, output dat, input ack);
  modport slave  (input req, input dat, output ack);
endinterface

// File: rtl/nd_2to1.sv
// nd_2to1: two-phase merge node, rcv0/rcv1 -> snd0, one message in flight.
// The chosen input is acked only after the downstream has acked the forwarded copy.
// All incoming handshake bits cross a 2-flop synchronizer.
// Optional feature: define NS_2TO1_FAIR_EN for round-robin arbitration;
// undefined gives fixed priority with rcv0 always winning.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 16
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 8
`endif

module nd_2to1 #(
  parameter int ASZ = `NS_ADDRESS_SIZE,
  parameter int DSZ = `NS_DATA_SIZE
) (
  input  logic      i_clk,
  input  logic      reset,
  output logic      ready,
  nd_2to1_if.slave  rcv0,
  nd_2to1_if.slave  rcv1,
  nd_2to1_if.master snd0
);

  // ASZ only keeps the link parameter list uniform; reject nonsense values early.
  if (ASZ < 1) begin : g_asz_chk
    $error("nd_2to1: ASZ must be at least 1");
  end

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t         state_q, state_d;
  logic           ready_q, ready_d;
  logic           sel_q, sel_d;
  logic [1:0]     rcv_ack_q, rcv_ack_d;
  logic           snd_req_q, snd_req_d;
  logic [DSZ-1:0] snd_dat_q, snd_dat_d;
  // synchronizer bit order: {snd0_ack, rcv1_req, rcv0_req}
  logic [2:0]     meta_q, meta_d;
  logic [2:0]     sync_q, sync_d;
  logic [1:0]     pend;
  logic           pick;
`ifdef NS_2TO1_FAIR_EN
  logic           last_q, last_d;
`endif

  // an input is pending when its synced req differs from our ack
  assign pend = sync_q[1:0] ^ rcv_ack_q;

  // arbitration: choose among pending inputs (pick is only used when pend != 0)
  always_comb begin
`ifdef NS_2TO1_FAIR_EN
    pick = (&pend) ? ~last_q : ~pend[0];
`else
    pick = ~pend[0];
`endif
  end

  // next-state logic for the synchronizers and the IDLE/WAIT machine
  always_comb begin
    meta_d    = {snd0.ack, rcv1.req, rcv0.req};
    sync_d    = meta_q;
    ready_d   = 1'b1;
    state_d   = state_q;
    sel_d     = sel_q;
    rcv_ack_d = rcv_ack_q;
    snd_req_d = snd_req_q;
    snd_dat_d = snd_dat_q;
`ifdef NS_2TO1_FAIR_EN
    last_d    = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (ready_q && (|pend)) begin
          // data of a pending input is already stable, safe to sample directly
          sel_d     = pick;
          snd_dat_d = pick ? rcv1.dat : rcv0.dat;
          snd_req_d = ~snd_req_q;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        if (sync_q[2] == snd_req_q) begin
          rcv_ack_d[sel_q] = ~rcv_ack_q[sel_q];
`ifdef NS_2TO1_FAIR_EN
          last_d = sel_q;
`endif
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // state and output registers, async active-low reset
  always_ff @(posedge i_clk or negedge reset) begin
    if (!reset) begin
      meta_q    <= '0;
      sync_q    <= '0;
      ready_q   <= 1'b0;
      state_q   <= IDLE;
      sel_q     <= 1'b0;
      rcv_ack_q <= '0;
      snd_req_q <= 1'b0;
      snd_dat_q <= '0;
`ifdef NS_2TO1_FAIR_EN
      last_q    <= 1'b1;
`endif
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      ready_q   <= ready_d;
      state_q   <= state_d;
      sel_q     <= sel_d;
      rcv_ack_q <= rcv_ack_d;
      snd_req_q <= snd_req_d;
      snd_dat_q <= snd_dat_d;
`ifdef NS_2TO1_FAIR_EN
      last_q    <= last_d;
`endif
    end
  end

  assign ready    = ready_q;
  assign rcv0.ack = rcv_ack_q[0];
  assign rcv1.ack = rcv_ack_q[1];
  assign snd0.req = snd_req_q;
  assign snd0.dat = snd_dat_q;

endmodule

// File: tb/tb_nd_2to1.sv
// Self-checking bench for nd_2to1: directed scenarios plus a random scoreboard run.
module tb_nd_2to1;
  localparam int DSZ = 8;

  logic i_clk = 1'b0;
  logic reset;
  logic ready;

  nd_2to1_if #(.DSZ(DSZ)) rcv0 ();
  nd_2to1_if #(.DSZ(DSZ)) rcv1 ();
  nd_2to1_if #(.DSZ(DSZ)) snd0 ();

  nd_2to1 #(.ASZ(16), .DSZ(DSZ)) dut (
    .i_clk (i_clk),
    .reset (reset),
    .ready (ready),
    .rcv0  (rcv0),
    .rcv1  (rcv1),
    .snd0  (snd0)
  );

  always #5 i_clk = ~i_clk;

  int             n_cmp = 0;
  int             n_err = 0;
  logic [DSZ-1:0] exp_q[$];
  logic [DSZ-1:0] q0[$];
  logic [DSZ-1:0] q1[$];
  bit             tb_last = 1'b1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  // wait (bounded) until snd0 carries an unacked message
  task automatic wait_launch(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (snd0.req !== snd0.ack) begin ok = 1'b1; break; end
      @(negedge i_clk);
    end
  endtask

  // wait (bounded) until input ch has been acked
  task automatic wait_done(input bit ch, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if ((ch ? rcv1.ack : rcv0.ack) === (ch ? rcv1.req : rcv0.req)) begin ok = 1'b1; break; end
      @(negedge i_clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    rcv0.req = 1'b0; rcv0.dat = '0;
    rcv1.req = 1'b0; rcv1.dat = '0;
    snd0.ack = 1'b0;
    repeat (3) begin
      @(negedge i_clk);
      n_cmp++;
      if ({ready, snd0.req, snd0.dat, rcv0.ack, rcv1.ack} !== '0) begin
        n_err++;
        $display("FAIL reset_outputs: got rdy=%b sreq=%b sdat=%h a0=%b a1=%b, want all 0",
                 ready, snd0.req, snd0.dat, rcv0.ack, rcv1.ack);
      end
    end
    reset = 1'b1;
    @(negedge i_clk);
    n_cmp++;
    if (ready !== 1'b1) begin n_err++; $display("FAIL ready_after_release: got %b want 1", ready); end
    repeat (4) @(negedge i_clk);
    n_cmp++;
    if (snd0.req !== 1'b0) begin n_err++; $display("FAIL idle_no_req: got %b want 0", snd0.req); end
    tb_last = 1'b1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [DSZ-1:0] want;
    rcv0.dat = 8'h33; rcv0.req = ~rcv0.req; exp_q.push_back(8'h33);
    wait_launch(20, ok);
    n_cmp++;
    want = exp_q.pop_front();
    if (!ok) begin n_err++; $display("FAIL rmid_launch: timeout, want launch"); end
    else if (snd0.dat !== want) begin n_err++; $display("FAIL rmid_dat: got %h want %h", snd0.dat, want); end
    repeat (2) @(negedge i_clk);
    reset = 1'b0;
    #1;
    n_cmp++;
    if ({ready, snd0.req, snd0.dat, rcv0.ack, rcv1.ack} !== '0) begin
      n_err++;
      $display("FAIL rmid_reset_outputs: got rdy=%b sreq=%b sdat=%h a0=%b a1=%b, want all 0",
               ready, snd0.req, snd0.dat, rcv0.ack, rcv1.ack);
    end
    @(negedge i_clk);
    reset = 1'b1;
    tb_last = 1'b1;
    exp_q.push_back(8'h33);
    wait_launch(30, ok);
    n_cmp++;
    want = exp_q.pop_front();
    if (!ok) begin n_err++; $display("FAIL rmid_resend: timeout, want resend of %h", want); end
    else if (snd0.dat !== want) begin n_err++; $display("FAIL rmid_resend_dat: got %h want %h", snd0.dat, want); end
    repeat (2) @(negedge i_clk);
    snd0.ack = ~snd0.ack;
    wait_done(1'b0, 20, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL rmid_done: rcv0 ack %b, want %b", rcv0.ack, rcv0.req); end
    tb_last = 1'b0;
  endtask

  task automatic test_single();
    logic r0, r1, s;
    logic [DSZ-1:0] want;
    r0 = rcv0.ack; r1 = rcv1.ack; s = snd0.req;
    rcv0.dat = 8'd5; rcv0.req = ~rcv0.req; exp_q.push_back(8'd5);
    repeat (2) @(negedge i_clk);
    n_cmp++;
    if (snd0.req !== s) begin n_err++; $display("FAIL single_early: snd0_req got %b want %b", snd0.req, s); end
    @(negedge i_clk);
    n_cmp++;
    want = exp_q.pop_front();
    if (snd0.req !== ~s || snd0.dat !== want) begin
      n_err++;
      $display("FAIL single_edge3: got req=%b dat=%h want req=%b dat=%h", snd0.req, snd0.dat, ~s, want);
    end
    repeat (4) @(negedge i_clk);
    snd0.ack = ~snd0.ack;
    repeat (2) @(negedge i_clk);
    n_cmp++;
    if (rcv0.ack !== r0) begin n_err++; $display("FAIL single_ack_early: got %b want %b", rcv0.ack, r0); end
    @(negedge i_clk);
    n_cmp++;
    if (rcv0.ack !== ~r0) begin n_err++; $display("FAIL single_ack_edge3: got %b want %b", rcv0.ack, ~r0); end
    n_cmp++;
    if (rcv1.ack !== r1) begin n_err++; $display("FAIL single_rcv1_ack: got %b want %b", rcv1.ack, r1); end
    tb_last = 1'b0;
  endtask

  task automatic test_both();
    bit ok, first, ch;
    logic a_other;
    logic [DSZ-1:0] want;
`ifdef NS_2TO1_FAIR_EN
    first = ~tb_last;
`else
    first = 1'b0;
`endif
    rcv0.dat = 8'd2; rcv1.dat = 8'd7;
    rcv0.req = ~rcv0.req; rcv1.req = ~rcv1.req;
    if (first) begin exp_q.push_back(8'd7); exp_q.push_back(8'd2); end
    else       begin exp_q.push_back(8'd2); exp_q.push_back(8'd7); end
    a_other = first ? rcv0.ack : rcv1.ack;
    for (int k = 0; k < 2; k++) begin
      ch = (k == 0) ? first : ~first;
      wait_launch(20, ok);
      n_cmp++;
      want = exp_q.pop_front();
      if (!ok) begin n_err++; $display("FAIL both_launch%0d: timeout, want %h", k, want); end
      else if (snd0.dat !== want) begin n_err++; $display("FAIL both_dat%0d: got %h want %h", k, snd0.dat, want); end
      repeat (2) @(negedge i_clk);
      snd0.ack = ~snd0.ack;
      wait_done(ch, 20, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL both_done%0d: input %0d not acked", k, ch); end
      if (k == 0) begin
        n_cmp++;
        if ((first ? rcv0.ack : rcv1.ack) !== a_other) begin
          n_err++; $display("FAIL both_loser_untouched: ack changed, want %b", a_other);
        end
      end
      tb_last = ch;
    end
  endtask

  task automatic test_stall();
    bit ok, stable;
    logic s_req, a0, a1;
    logic [DSZ-1:0] s_dat, want;
    rcv0.dat = 8'h44; rcv0.req = ~rcv0.req; exp_q.push_back(8'h44);
    wait_launch(20, ok);
    n_cmp++;
    want = exp_q.pop_front();
    if (!ok) begin n_err++; $display("FAIL stall_launch: timeout, want %h", want); end
    else if (snd0.dat !== want) begin n_err++; $display("FAIL stall_dat: got %h want %h", snd0.dat, want); end
    s_req = snd0.req; s_dat = snd0.dat; a0 = rcv0.ack; a1 = rcv1.ack;
    stable = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (i == 10) begin rcv1.dat = 8'h99; rcv1.req = ~rcv1.req; exp_q.push_back(8'h99); end
      @(negedge i_clk);
      if (snd0.req !== s_req || snd0.dat !== s_dat || rcv0.ack !== a0 || rcv1.ack !== a1) stable = 1'b0;
    end
    n_cmp++;
    if (!stable) begin n_err++; $display("FAIL stall_stable: outputs moved, want req=%b dat=%h held", s_req, s_dat); end
    snd0.ack = ~snd0.ack;
    wait_done(1'b0, 20, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL stall_done0: rcv0 ack %b want %b", rcv0.ack, rcv0.req); end
    wait_launch(20, ok);
    n_cmp++;
    want = exp_q.pop_front();
    if (!ok) begin n_err++; $display("FAIL stall_rcv1_lost: timeout, want %h", want); end
    else if (snd0.dat !== want) begin n_err++; $display("FAIL stall_rcv1_dat: got %h want %h", snd0.dat, want); end
    snd0.ack = ~snd0.ack;
    wait_done(1'b1, 20, ok);
    n_cmp++;
    if (!ok) begin n_err++; $display("FAIL stall_done1: rcv1 ack %b want %b", rcv1.ack, rcv1.req); end
    tb_last = 1'b1;
  endtask

  task automatic send_rand(input bit ch, input int n);
    bit ok;
    logic [DSZ-1:0] d;
    for (int i = 0; i < n; i++) begin
      ok = 1'b0;
      for (int t = 0; t < 3000; t++) begin
        if ((ch ? rcv1.ack : rcv0.ack) === (ch ? rcv1.req : rcv0.req)) begin ok = 1'b1; break; end
        @(negedge i_clk);
      end
      if (!ok) begin n_cmp++; n_err++; $display("FAIL rand_send%0d: ack timeout at msg %0d", ch, i); break; end
      repeat ($urandom_range(0, 3)) @(negedge i_clk);
      d = {ch, i[6:0]};
      if (ch) begin rcv1.dat = d; q1.push_back(d); rcv1.req = ~rcv1.req; end
      else    begin rcv0.dat = d; q0.push_back(d); rcv0.req = ~rcv0.req; end
      @(negedge i_clk);
    end
  endtask

  task automatic sink_rand(input int n);
    bit ok;
    logic [DSZ-1:0] d, want;
    for (int k = 0; k < n; k++) begin
      wait_launch(3000, ok);
      if (!ok) begin n_cmp++; n_err++; $display("FAIL rand_sink: launch timeout at msg %0d", k); break; end
      d = snd0.dat;
      n_cmp++;
      if (d[7] == 1'b0) begin
        want = (q0.size() != 0) ? q0.pop_front() : 'x;
      end else begin
        want = (q1.size() != 0) ? q1.pop_front() : 'x;
      end
      if (d !== want) begin n_err++; $display("FAIL rand_order: got %h want %h", d, want); end
      repeat ($urandom_range(0, 5)) @(negedge i_clk);
      snd0.ack = ~snd0.ack;
      @(negedge i_clk);
    end
  endtask

  task automatic test_random();
    fork
      send_rand(1'b0, 100);
      send_rand(1'b1, 100);
      sink_rand(200);
    join
    n_cmp++;
    if (q0.size() != 0 || q1.size() != 0) begin
      n_err++; $display("FAIL rand_leftover: q0=%0d q1=%0d undelivered, want 0", q0.size(), q1.size());
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_single();
    test_both();
    test_stall();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
